// File: rtl/id_ex_pipeline_register_if.sv
// ID/EX boundary bus: the ID-side control/data bundle, the stage
// handshake (LE/FLUSH), and the registered EX-side copies.
interface id_ex_pipeline_register_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);

  // stage handshake
  logic              LE;
  logic              FLUSH;

  // ID-side bundle
  logic              ID_VALID;
  logic [3:0]        ID_ALU_OP;
  logic              ID_LOAD_INSTR;
  logic              ID_RF_ENABLE;
  logic              ID_HI_ENABLE;
  logic              ID_LO_ENABLE;
  logic              ID_PC_PLUS8_INSTR;
  logic              ID_UB_INSTR;
  logic              ID_JALR_JR_INSTR;
  logic              ID_MEM_ENABLE;
  logic              ID_MEM_READWRITE;
  logic              ID_MEM_SIGNE;
  logic [2:0]        ID_OP_H_S;
  logic [1:0]        ID_MEM_SIZE;
  logic [4:0]        ID_DEST_REG;
  logic [DATA_W-1:0] ID_PA;
  logic [DATA_W-1:0] ID_PB;
  logic [DATA_W-1:0] ID_PC8;
  logic [15:0]       ID_IMM16;

  // EX-side registered bundle
  logic              EX_VALID;
  logic [3:0]        EX_ALU_OP;
  logic              EX_LOAD_INSTR;
  logic              EX_RF_ENABLE;
  logic              EX_HI_ENABLE;
  logic              EX_LO_ENABLE;
  logic              EX_PC_PLUS8_INSTR;
  logic              EX_UB_INSTR;
  logic              EX_JALR_JR_INSTR;
  logic              EX_MEM_ENABLE;
  logic              EX_MEM_READWRITE;
  logic              EX_MEM_SIGNE;
  logic [2:0]        EX_OP_H_S;
  logic [1:0]        EX_MEM_SIZE;
  logic [4:0]        EX_DEST_REG;
  logic [DATA_W-1:0] EX_PA;
  logic [DATA_W-1:0] EX_PB;
  logic [DATA_W-1:0] EX_PC8;
  logic [15:0]       EX_IMM16;
  logic [CNT_W-1:0]  BUBBLE_CNT;

  // ID stage / hazard unit side
  modport master (
    output LE, FLUSH,
    output ID_VALID, ID_ALU_OP, ID_LOAD_INSTR, ID_RF_ENABLE, ID_HI_ENABLE,
           ID_LO_ENABLE, ID_PC_PLUS8_INSTR, ID_UB_INSTR, ID_JALR_JR_INSTR,
           ID_MEM_ENABLE, ID_MEM_READWRITE, ID_MEM_SIGNE, ID_OP_H_S,
           ID_MEM_SIZE, ID_DEST_REG, ID_PA, ID_PB, ID_PC8, ID_IMM16,
    input  EX_VALID, EX_ALU_OP, EX_LOAD_INSTR, EX_RF_ENABLE, EX_HI_ENABLE,
           EX_LO_ENABLE, EX_PC_PLUS8_INSTR, EX_UB_INSTR, EX_JALR_JR_INSTR,
           EX_MEM_ENABLE, EX_MEM_READWRITE, EX_MEM_SIGNE, EX_OP_H_S,
           EX_MEM_SIZE, EX_DEST_REG, EX_PA, EX_PB, EX_PC8, EX_IMM16,
           BUBBLE_CNT
  );

  // pipeline register side
  modport slave (
    input  LE, FLUSH,
    input  ID_VALID, ID_ALU_OP, ID_LOAD_INSTR, ID_RF_ENABLE, ID_HI_ENABLE,
           ID_LO_ENABLE, ID_PC_PLUS8_INSTR, ID_UB_INSTR, ID_JALR_JR_INSTR,
           ID_MEM_ENABLE, ID_MEM_READWRITE, ID_MEM_SIGNE, ID_OP_H_S,
           ID_MEM_SIZE, ID_DEST_REG, ID_PA, ID_PB, ID_PC8, ID_IMM16,
    output EX_VALID, EX_ALU_OP, EX_LOAD_INSTR, EX_RF_ENABLE, EX_HI_ENABLE,
           EX_LO_ENABLE, EX_PC_PLUS8_INSTR, EX_UB_INSTR, EX_JALR_JR_INSTR,
           EX_MEM_ENABLE, EX_MEM_READWRITE, EX_MEM_SIGNE, EX_OP_H_S,
           EX_MEM_SIZE, EX_DEST_REG, EX_PA, EX_PB, EX_PC8, EX_IMM16,
           BUBBLE_CNT
  );

endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline boundary register. Captures the hazard-gated control
// bundle and operand data once per cycle, supports stall (hold), flush
// (bubble insert), suppresses register-file writes to R0, and counts
// inserted bubbles in a saturating debug counter.
module id_ex_pipeline_register #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  id_ex_pipeline_register_if.slave      bus
);

  logic              r_valid;
  logic [3:0]        r_aluOp;
  logic              r_loadInstr;
  logic              r_rfEnable;
  logic              r_hiEnable;
  logic              r_loEnable;
  logic              r_pcPlus8Instr;
  logic              r_ubInstr;
  logic              r_jalrJrInstr;
  logic              r_memEnable;
  logic              r_memReadWrite;
  logic              r_memSigne;
  logic [2:0]        r_opHS;
  logic [1:0]        r_memSize;
  logic [4:0]        r_destReg;
  logic [DATA_W-1:0] r_pa;
  logic [DATA_W-1:0] r_pb;
  logic [DATA_W-1:0] r_pc8;
  logic [15:0]       r_imm16;
  logic [CNT_W-1:0]  r_bubbleCnt;

  logic              w_rfEnableGated;
  logic              w_cntSaturated;

  // A write to R0 is architecturally a no-op, so drop the write enable here
  // rather than letting EX/MEM/WB carry a pointless write downstream.
  assign w_rfEnableGated = bus.ID_RF_ENABLE & (bus.ID_DEST_REG != 5'd0);
  assign w_cntSaturated  = (r_bubbleCnt == {CNT_W{1'b1}});

  // Control bundle: flush forces a NOP, load captures, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid        <= 1'b0;
      r_aluOp        <= 4'd0;
      r_loadInstr    <= 1'b0;
      r_rfEnable     <= 1'b0;
      r_hiEnable     <= 1'b0;
      r_loEnable     <= 1'b0;
      r_pcPlus8Instr <= 1'b0;
      r_ubInstr      <= 1'b0;
      r_jalrJrInstr  <= 1'b0;
      r_memEnable    <= 1'b0;
      r_memReadWrite <= 1'b0;
      r_memSigne     <= 1'b0;
      r_opHS         <= 3'd0;
      r_memSize      <= 2'd0;
      r_destReg      <= 5'd0;
    end else if (bus.FLUSH) begin
      r_valid        <= 1'b0;
      r_aluOp        <= 4'd0;
      r_loadInstr    <= 1'b0;
      r_rfEnable     <= 1'b0;
      r_hiEnable     <= 1'b0;
      r_loEnable     <= 1'b0;
      r_pcPlus8Instr <= 1'b0;
      r_ubInstr      <= 1'b0;
      r_jalrJrInstr  <= 1'b0;
      r_memEnable    <= 1'b0;
      r_memReadWrite <= 1'b0;
      r_memSigne     <= 1'b0;
      r_opHS         <= 3'd0;
      r_memSize      <= 2'd0;
      r_destReg      <= 5'd0;
    end else if (bus.LE) begin
      r_valid        <= bus.ID_VALID;
      r_aluOp        <= bus.ID_ALU_OP;
      r_loadInstr    <= bus.ID_LOAD_INSTR;
      r_rfEnable     <= w_rfEnableGated;
      r_hiEnable     <= bus.ID_HI_ENABLE;
      r_loEnable     <= bus.ID_LO_ENABLE;
      r_pcPlus8Instr <= bus.ID_PC_PLUS8_INSTR;
      r_ubInstr      <= bus.ID_UB_INSTR;
      r_jalrJrInstr  <= bus.ID_JALR_JR_INSTR;
      r_memEnable    <= bus.ID_MEM_ENABLE;
      r_memReadWrite <= bus.ID_MEM_READWRITE;
      r_memSigne     <= bus.ID_MEM_SIGNE;
      r_opHS         <= bus.ID_OP_H_S;
      r_memSize      <= bus.ID_MEM_SIZE;
      r_destReg      <= bus.ID_DEST_REG;
    end
  end

  // Operand data: cleared on flush so a bubble carries no stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pa    <= '0;
      r_pb    <= '0;
      r_pc8   <= '0;
      r_imm16 <= 16'd0;
    end else if (bus.FLUSH) begin
      r_pa    <= '0;
      r_pb    <= '0;
      r_pc8   <= '0;
      r_imm16 <= 16'd0;
    end else if (bus.LE) begin
      r_pa    <= bus.ID_PA;
      r_pb    <= bus.ID_PB;
      r_pc8   <= bus.ID_PC8;
      r_imm16 <= bus.ID_IMM16;
    end
  end

  // Bubble counter: one step per flush cycle, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubbleCnt <= '0;
    end else if (bus.FLUSH && !w_cntSaturated) begin
      r_bubbleCnt <= r_bubbleCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.EX_VALID          = r_valid;
  assign bus.EX_ALU_OP         = r_aluOp;
  assign bus.EX_LOAD_INSTR     = r_loadInstr;
  assign bus.EX_RF_ENABLE      = r_rfEnable;
  assign bus.EX_HI_ENABLE      = r_hiEnable;
  assign bus.EX_LO_ENABLE      = r_loEnable;
  assign bus.EX_PC_PLUS8_INSTR = r_pcPlus8Instr;
  assign bus.EX_UB_INSTR       = r_ubInstr;
  assign bus.EX_JALR_JR_INSTR  = r_jalrJrInstr;
  assign bus.EX_MEM_ENABLE     = r_memEnable;
  assign bus.EX_MEM_READWRITE  = r_memReadWrite;
  assign bus.EX_MEM_SIGNE      = r_memSigne;
  assign bus.EX_OP_H_S         = r_opHS;
  assign bus.EX_MEM_SIZE       = r_memSize;
  assign bus.EX_DEST_REG       = r_destReg;
  assign bus.EX_PA             = r_pa;
  assign bus.EX_PB             = r_pb;
  assign bus.EX_PC8            = r_pc8;
  assign bus.EX_IMM16          = r_imm16;
  assign bus.BUBBLE_CNT        = r_bubbleCnt;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for the ID/EX pipeline register: directed scenarios followed by
// randomized traffic, all compared against a field-level reference model.
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        valid;
    logic [3:0]  aluOp;
    logic        load;
    logic        rf;
    logic        hi;
    logic        lo;
    logic        pc8i;
    logic        ub;
    logic        jalr;
    logic        memEn;
    logic        memRw;
    logic        memSigne;
    logic [2:0]  opHs;
    logic [1:0]  memSize;
    logic [4:0]  dest;
    logic [31:0] pa;
    logic [31:0] pb;
    logic [31:0] pc8;
    logic [15:0] imm16;
  } exFields_t;

  typedef struct packed {
    logic      le;
    logic      flush;
    exFields_t id;
  } stim_t;

  logic clk;
  logic rst_n;

  id_ex_pipeline_register_if #(.DATA_W(32), .CNT_W(8)) bus();
  id_ex_pipeline_register_if #(.DATA_W(32), .CNT_W(2)) bus2();

  id_ex_pipeline_register #(.DATA_W(32), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  id_ex_pipeline_register #(.DATA_W(32), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int        checkCount = 0;
  int        passCount  = 0;
  exFields_t expEx;
  int        expCnt;
  stim_t     s;

  // free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  function automatic exFields_t readObs();
    exFields_t o;
    o.valid    = bus.EX_VALID;
    o.aluOp    = bus.EX_ALU_OP;
    o.load     = bus.EX_LOAD_INSTR;
    o.rf       = bus.EX_RF_ENABLE;
    o.hi       = bus.EX_HI_ENABLE;
    o.lo       = bus.EX_LO_ENABLE;
    o.pc8i     = bus.EX_PC_PLUS8_INSTR;
    o.ub       = bus.EX_UB_INSTR;
    o.jalr     = bus.EX_JALR_JR_INSTR;
    o.memEn    = bus.EX_MEM_ENABLE;
    o.memRw    = bus.EX_MEM_READWRITE;
    o.memSigne = bus.EX_MEM_SIGNE;
    o.opHs     = bus.EX_OP_H_S;
    o.memSize  = bus.EX_MEM_SIZE;
    o.dest     = bus.EX_DEST_REG;
    o.pa       = bus.EX_PA;
    o.pb       = bus.EX_PB;
    o.pc8      = bus.EX_PC8;
    o.imm16    = bus.EX_IMM16;
    return o;
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, "_ex"}, 160'(readObs()), 160'(expEx));
    checkOutput({tag, "_cnt"}, 160'(bus.BUBBLE_CNT), 160'(expCnt));
  endtask

  function automatic stim_t randomStim();
    stim_t r;
    r.le          = ($urandom_range(0, 3) != 0);
    r.flush       = ($urandom_range(0, 7) == 0);
    r.id.valid    = 1'($urandom);
    r.id.aluOp    = 4'($urandom);
    r.id.load     = 1'($urandom);
    r.id.rf       = 1'($urandom);
    r.id.hi       = 1'($urandom);
    r.id.lo       = 1'($urandom);
    r.id.pc8i     = 1'($urandom);
    r.id.ub       = 1'($urandom);
    r.id.jalr     = 1'($urandom);
    r.id.memEn    = 1'($urandom);
    r.id.memRw    = 1'($urandom);
    r.id.memSigne = 1'($urandom);
    r.id.opHs     = 3'($urandom);
    r.id.memSize  = 2'($urandom);
    r.id.dest     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    r.id.pa       = $urandom;
    r.id.pb       = $urandom;
    r.id.pc8      = $urandom;
    r.id.imm16    = 16'($urandom);
    return r;
  endfunction

  // reference: what EX should hold after one edge with stimulus st
  task automatic modelEdge(input stim_t st);
    if (st.flush) begin
      expEx  = '0;
      expCnt = (expCnt < 255) ? expCnt + 1 : 255;
    end else if (st.le) begin
      expEx = st.id;
      if (st.id.dest == 5'd0) expEx.rf = 1'b0;
    end
  endtask

  task automatic driveBus(input stim_t st);
    bus.LE                = st.le;
    bus.FLUSH             = st.flush;
    bus.ID_VALID          = st.id.valid;
    bus.ID_ALU_OP         = st.id.aluOp;
    bus.ID_LOAD_INSTR     = st.id.load;
    bus.ID_RF_ENABLE      = st.id.rf;
    bus.ID_HI_ENABLE      = st.id.hi;
    bus.ID_LO_ENABLE      = st.id.lo;
    bus.ID_PC_PLUS8_INSTR = st.id.pc8i;
    bus.ID_UB_INSTR       = st.id.ub;
    bus.ID_JALR_JR_INSTR  = st.id.jalr;
    bus.ID_MEM_ENABLE     = st.id.memEn;
    bus.ID_MEM_READWRITE  = st.id.memRw;
    bus.ID_MEM_SIGNE      = st.id.memSigne;
    bus.ID_OP_H_S         = st.id.opHs;
    bus.ID_MEM_SIZE       = st.id.memSize;
    bus.ID_DEST_REG       = st.id.dest;
    bus.ID_PA             = st.id.pa;
    bus.ID_PB             = st.id.pb;
    bus.ID_PC8            = st.id.pc8;
    bus.ID_IMM16          = st.id.imm16;
  endtask

  // called just after a falling edge; returns just after the next one
  task automatic applyStimulus(input stim_t st, input string tag);
    driveBus(st);
    #1;
    checkState({tag, "_pre"});
    @(posedge clk);
    modelEdge(st);
    @(negedge clk);
    checkState({tag, "_post"});
  endtask

  initial begin
    int satSeq [5];
    satSeq = '{1, 2, 3, 3, 3};

    rst_n  = 1'b0;
    expEx  = '0;
    expCnt = 0;
    s      = '0;
    driveBus(s);
    bus2.LE = 1'b0;
    bus2.FLUSH = 1'b0;
    bus2.ID_VALID = 1'b0;          bus2.ID_ALU_OP = 4'd0;
    bus2.ID_LOAD_INSTR = 1'b0;     bus2.ID_RF_ENABLE = 1'b0;
    bus2.ID_HI_ENABLE = 1'b0;      bus2.ID_LO_ENABLE = 1'b0;
    bus2.ID_PC_PLUS8_INSTR = 1'b0; bus2.ID_UB_INSTR = 1'b0;
    bus2.ID_JALR_JR_INSTR = 1'b0;  bus2.ID_MEM_ENABLE = 1'b0;
    bus2.ID_MEM_READWRITE = 1'b0;  bus2.ID_MEM_SIGNE = 1'b0;
    bus2.ID_OP_H_S = 3'd0;         bus2.ID_MEM_SIZE = 2'd0;
    bus2.ID_DEST_REG = 5'd0;       bus2.ID_PA = 32'd0;
    bus2.ID_PB = 32'd0;            bus2.ID_PC8 = 32'd0;
    bus2.ID_IMM16 = 16'd0;

    @(negedge clk);
    @(negedge clk);
    checkState("reset");
    checkOutput("reset_cnt2", 160'(bus2.BUBBLE_CNT), 160'(0));
    rst_n = 1'b1;

    // normal capture
    s = randomStim();
    s.le = 1'b1; s.flush = 1'b0;
    s.id.pa = 32'h1234_5678; s.id.dest = 5'd9; s.id.rf = 1'b1; s.id.memSize = 2'b10;
    applyStimulus(s, "capture");
    checkOutput("capture_pa", 160'(bus.EX_PA), 160'(32'h1234_5678));
    checkOutput("capture_dest", 160'(bus.EX_DEST_REG), 160'(9));
    checkOutput("capture_rf", 160'(bus.EX_RF_ENABLE), 160'(1));
    checkOutput("capture_size", 160'(bus.EX_MEM_SIZE), 160'(2));

    // stall
    s = randomStim();
    s.le = 1'b1; s.flush = 1'b0; s.id.aluOp = 4'd3;
    applyStimulus(s, "stall_load");
    s.le = 1'b0; s.id.aluOp = 4'd7;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(s, "stall_hold");
      checkOutput("stall_aluop", 160'(bus.EX_ALU_OP), 160'(3));
    end
    s.le = 1'b1;
    applyStimulus(s, "stall_release");
    checkOutput("release_aluop", 160'(bus.EX_ALU_OP), 160'(7));

    // flush priority
    s = randomStim();
    s.le = 1'b1; s.flush = 1'b1; s.id.memEn = 1'b1; s.id.memRw = 1'b1; s.id.valid = 1'b1;
    applyStimulus(s, "flush_le1");
    checkOutput("flush_memen", 160'(bus.EX_MEM_ENABLE), 160'(0));
    checkOutput("flush_valid", 160'(bus.EX_VALID), 160'(0));
    checkOutput("flush_cnt1", 160'(bus.BUBBLE_CNT), 160'(1));
    s.le = 1'b0;
    applyStimulus(s, "flush_le0");
    checkOutput("flush_cnt2", 160'(bus.BUBBLE_CNT), 160'(2));

    // R0 write suppress
    s = randomStim();
    s.le = 1'b1; s.flush = 1'b0; s.id.dest = 5'd0; s.id.rf = 1'b1;
    applyStimulus(s, "r0");
    checkOutput("r0_rf", 160'(bus.EX_RF_ENABLE), 160'(0));
    checkOutput("r0_dest", 160'(bus.EX_DEST_REG), 160'(0));
    s.id.dest = 5'd31;
    applyStimulus(s, "r31");
    checkOutput("r31_rf", 160'(bus.EX_RF_ENABLE), 160'(1));

    // reset mid-run, between clock edges
    s = randomStim();
    s.le = 1'b1; s.flush = 1'b0; s.id.aluOp = 4'hA; s.id.rf = 1'b1; s.id.dest = 5'd5;
    applyStimulus(s, "prereset");
    #2 rst_n = 1'b0;
    #1;
    expEx  = '0;
    expCnt = 0;
    checkState("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      s = randomStim();
      applyStimulus(s, "rand");
    end

    // saturation on the narrow-counter instance
    for (int i = 0; i < 5; i++) begin
      bus2.FLUSH = 1'b1;
      bus2.LE    = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      checkOutput("sat_cnt", 160'(bus2.BUBBLE_CNT), 160'(satSeq[i]));
    end
    bus2.FLUSH = 1'b0;
    bus2.LE    = 1'b0;
    @(negedge clk);
    checkOutput("sat_hold", 160'(bus2.BUBBLE_CNT), 160'(3));

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
